// File: rtl/uart_rx.sv
// uart_rx: UART receiver, mid-bit sampling, LSB first, valid/ready output with framing and overrun flags.
// Optional macro UART_RX_PARITY_EN switches to 8E1 frames and adds the parity_err_o pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       overrun_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shreg;
    logic             r_deliver;
    logic [7:0]       r_rx_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_half_hit;
    logic             w_full_hit;
    logic             w_shift_en;
    logic             w_stop_ok;
    logic             w_stop_bad;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad;
    logic             r_parity_err;
    logic             w_par_sample;
`endif

    assign w_half_hit = (r_cnt == HALF_LAST);
    assign w_full_hit = (r_cnt == FULL_LAST);

    // Synchroniser idles high so a reset release never looks like a start edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_state_next = S_START;
            end
            S_START: begin
                if (w_half_hit) w_state_next = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_full_hit) begin
                    w_shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (r_idx == 3'd7) w_state_next = S_PARITY;
`else
                    if (r_idx == 3'd7) w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_full_hit) begin
                    w_par_sample = 1'b1;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_full_hit) begin
                    if (r_rx_s) begin
                        w_stop_ok    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (r_rx_s) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counter restarts on each state change and on every full bit period inside DATA.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if ((w_state_next != r_state) || w_full_hit || (r_state == S_IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_idx   <= 3'd0;
            r_shreg <= 8'h00;
        end else begin
            if (r_state == S_START) begin
                r_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_shift_en) r_shreg[r_idx] <= r_rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_sample) r_par_bad <= r_rx_s ^ (^r_shreg);
            r_parity_err <= w_stop_ok & r_par_bad;
        end
    end
    assign parity_err_o = r_parity_err;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_deliver   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
`ifdef UART_RX_PARITY_EN
            r_deliver   <= w_stop_ok & ~r_par_bad;
`else
            r_deliver   <= w_stop_ok;
`endif
            r_frame_err <= w_stop_bad;
        end
    end

    // Output holding register: a delivery onto an unaccepted byte is dropped and flagged.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rx_data <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_deliver) begin
                if (r_valid && !ready_i) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_rx_data <= r_shreg;
                    r_valid   <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data_o   = r_rx_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks bytes, handshake and error pulses
// against a transaction-level model of the receiver's holding register.
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b1;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] rx_data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    always #5 clk_i = ~clk_i;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rx_i        (rx_i),
        .rx_data_o   (rx_data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .overrun_o   (overrun_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor on the falling edge: counts pulses and logs every accepted byte.
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         pe_cnt    = 0;
    int         rise_cnt  = 0;
    int         clash_cnt = 0;
    logic       valid_d   = 1'b0;
    logic [7:0] acc_q[$];

    always @(negedge clk_i) begin
        if (frame_err_o) fe_cnt++;
        if (overrun_o) ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err_o) pe_cnt++;
        if (valid_o && !valid_d && parity_err_o) clash_cnt++;
`endif
        if (valid_o && !valid_d) rise_cnt++;
        if (valid_o && !valid_d && (frame_err_o || overrun_o)) clash_cnt++;
        if (valid_o && ready_i) acc_q.push_back(rx_data_o);
        valid_d = valid_o;
    end

    task automatic drive_bit(input logic b, input int nclk);
        rx_i = b;
        repeat (nclk) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip, CPB);
`else
        if (par_flip) n_fail += 0;
`endif
        drive_bit(stop_b, CPB);
    endtask

    task automatic accept_one();
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        rx_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        n_tests++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_tests++;
        if (rx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data_o); end
        n_tests++;
        if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err_o); end
        n_tests++;
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        reset_i = 1'b0;
        repeat (100) @(posedge clk_i);
        #1;
        n_tests++;
        if (valid_o !== 1'b0 || rise_cnt != 0) begin
            n_fail++; $display("FAIL idle_no_valid: valid=%b rises=%0d want 0/0", valid_o, rise_cnt);
        end
        $display("[TB] reset and idle checked");
    endtask

    task automatic test_basic();
        int acc0 = acc_q.size();
        ready_i = 1'b0;
        send_frame(8'h6C, 1'b1, 1'b0);
        n_tests++;
        if (valid_o !== 1'b1 || rx_data_o !== 8'h6C) begin
            n_fail++; $display("FAIL basic_rx: valid=%b data=%h want 1/6c", valid_o, rx_data_o);
        end
        repeat (40) @(posedge clk_i);
        #1;
        n_tests++;
        if (valid_o !== 1'b1 || rx_data_o !== 8'h6C) begin
            n_fail++; $display("FAIL basic_hold: valid=%b data=%h want 1/6c", valid_o, rx_data_o);
        end
        accept_one();
        n_tests++;
        if (valid_o !== 1'b0 || rx_data_o !== 8'h6C) begin
            n_fail++; $display("FAIL basic_accept: valid=%b data=%h want 0/6c", valid_o, rx_data_o);
        end
        n_tests++;
        if (acc_q.size() != acc0 + 1) begin
            n_fail++; $display("FAIL basic_accept_count: got %0d want %0d", acc_q.size() - acc0, 1);
        end
        $display("[TB] basic frame 0x6c checked");
    endtask

    task automatic test_glitch();
        int fe0 = fe_cnt;
        int r0  = rise_cnt;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 3 * CPB);
        n_tests++;
        if (rise_cnt != r0 || fe_cnt != fe0) begin
            n_fail++; $display("FAIL glitch_reject: rises=%0d ferr=%0d want 0/0", rise_cnt - r0, fe_cnt - fe0);
        end
        send_frame(8'h88, 1'b1, 1'b0);
        n_tests++;
        if (valid_o !== 1'b1 || rx_data_o !== 8'h88) begin
            n_fail++; $display("FAIL glitch_next_frame: valid=%b data=%h want 1/88", valid_o, rx_data_o);
        end
        accept_one();
        $display("[TB] glitch rejection checked");
    endtask

    task automatic test_frame_err();
        int fe0 = fe_cnt;
        int r0  = rise_cnt;
        send_frame(8'hA5, 1'b0, 1'b0);
        drive_bit(1'b0, 3 * CPB);
        n_tests++;
        if (fe_cnt - fe0 != 1) begin
            n_fail++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt - fe0);
        end
        n_tests++;
        if (rise_cnt != r0 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL frame_err_no_valid: rises=%0d valid=%b want 0/0", rise_cnt - r0, valid_o);
        end
        drive_bit(1'b1, 2 * CPB);
        send_frame(8'h3C, 1'b1, 1'b0);
        n_tests++;
        if (valid_o !== 1'b1 || rx_data_o !== 8'h3C || fe_cnt - fe0 != 1) begin
            n_fail++; $display("FAIL frame_err_recover: valid=%b data=%h ferr=%0d want 1/3c/1", valid_o, rx_data_o, fe_cnt - fe0);
        end
        accept_one();
        $display("[TB] framing error checked");
    endtask

    task automatic test_back_to_back();
        int ov0 = ov_cnt;
        int acc0;
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        n_tests++;
        if (valid_o !== 1'b1 || rx_data_o !== 8'h11) begin
            n_fail++; $display("FAIL overrun_keep_old: valid=%b data=%h want 1/11", valid_o, rx_data_o);
        end
        n_tests++;
        if (ov_cnt - ov0 != 1) begin
            n_fail++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt - ov0);
        end
        accept_one();
        ov0     = ov_cnt;
        acc0    = acc_q.size();
        ready_i = 1'b1;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        n_tests++;
        if (acc_q.size() != acc0 + 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 2", acc_q.size() - acc0);
        end else begin
            n_tests++;
            if (acc_q[acc0] !== 8'h11 || acc_q[acc0+1] !== 8'h22) begin
                n_fail++; $display("FAIL b2b_order: got %h %h want 11 22", acc_q[acc0], acc_q[acc0+1]);
            end
        end
        n_tests++;
        if (ov_cnt != ov0) begin
            n_fail++; $display("FAIL b2b_no_overrun: got %0d want 0", ov_cnt - ov0);
        end
        $display("[TB] back-to-back and overrun checked");
    endtask

    task automatic test_reset_midframe();
        int fe0 = fe_cnt;
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b0, CPB / 2);
        rx_i    = 1'b1;
        reset_i = 1'b1;
        #1;
        n_tests++;
        if (valid_o !== 1'b0 || rx_data_o !== 8'h00 || frame_err_o !== 1'b0) begin
            n_fail++; $display("FAIL midframe_reset: valid=%b data=%h ferr=%b want 0/00/0", valid_o, rx_data_o, frame_err_o);
        end
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        drive_bit(1'b1, CPB);
        send_frame(8'h5A, 1'b1, 1'b0);
        n_tests++;
        if (valid_o !== 1'b1 || rx_data_o !== 8'h5A || fe_cnt != fe0) begin
            n_fail++; $display("FAIL midframe_recover: valid=%b data=%h ferr=%0d want 1/5a/0", valid_o, rx_data_o, fe_cnt - fe0);
        end
        accept_one();
        $display("[TB] mid-frame reset checked");
    endtask

    // Random frames, stop bits, parity and consumer readiness against a holding-register model.
    task automatic test_random();
        logic [7:0] d;
        logic       stop_b;
        logic       par_flip;
        logic       rdy;
        logic       m_valid = 1'b0;
        logic [7:0] m_data  = 8'h00;
        logic [7:0] exp_q[$];
        int         exp_fe = 0, exp_ov = 0, exp_pe = 0;
        int         fe0 = fe_cnt, ov0 = ov_cnt, pe0 = pe_cnt;
        acc_q.delete();
        for (int k = 0; k < 30; k++) begin
            d        = 8'($urandom);
            stop_b   = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
            par_flip = ($urandom_range(0, 4) == 0);
`else
            par_flip = 1'b0;
`endif
            rdy      = 1'($urandom_range(0, 1));
            ready_i  = rdy;
            if (rdy && m_valid) begin
                exp_q.push_back(m_data);
                m_valid = 1'b0;
            end
            send_frame(d, stop_b, par_flip);
            if (!stop_b) begin
                exp_fe++;
                drive_bit(1'b1, CPB);
            end else if (par_flip) begin
                exp_pe++;
            end else if (m_valid && !rdy) begin
                exp_ov++;
            end else if (rdy) begin
                exp_q.push_back(d);
            end else begin
                m_valid = 1'b1;
                m_data  = d;
            end
            drive_bit(1'b1, $urandom_range(0, CPB));
        end
        ready_i = 1'b1;
        if (m_valid) exp_q.push_back(m_data);
        repeat (3) @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        n_tests++;
        if (acc_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d bytes want %0d", acc_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (acc_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand_byte[%0d]: got %h want %h", i, acc_q[i], exp_q[i]);
                end
            end
        end
        n_tests++;
        if (fe_cnt - fe0 != exp_fe) begin
            n_fail++; $display("FAIL rand_frame_err: got %0d want %0d", fe_cnt - fe0, exp_fe);
        end
        n_tests++;
        if (ov_cnt - ov0 != exp_ov) begin
            n_fail++; $display("FAIL rand_overrun: got %0d want %0d", ov_cnt - ov0, exp_ov);
        end
        n_tests++;
        if (pe_cnt - pe0 != exp_pe) begin
            n_fail++; $display("FAIL rand_parity_err: got %0d want %0d", pe_cnt - pe0, exp_pe);
        end
        n_tests++;
        if (clash_cnt != 0 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rand_pulse_clash: clashes=%0d valid=%b want 0/0", clash_cnt, valid_o);
        end
        $display("[TB] random frames: %0d bytes, %0d ferr, %0d ovr, %0d perr expected",
                 exp_q.size(), exp_fe, exp_ov, exp_pe);
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
